// File: rtl/flag_commit.sv
// ---------------------------------------------------------------------------
// flag_commit
//
// Architected XER/CR flag state at writeback. The ALU hands over a packed
// flag vector D = {CA,OV,LT0,GT0,EQ0,LTx,GTx,EQx} together with write
// enables. Move-to ops (mtxer, mtcrf, mcrxr) also write the same state.
// XERrd/CRrd return the current flags to the ALU.
//
// A one-entry hold buffer absorbs an ALU update that arrives in the same
// cycle as a move-to op. The move-to op is older, so it applies first and
// the update is parked. The parked update then applies on the next cycle
// that carries no move-to op. An update is delayed this way but never lost.
//
// Bit 0 is the MSB on every vector port.
//   XER : SO = bit 0, OV = bit 1, CA = bit 2
//   CR  : field i = bits 4i..4i+3 = {LT,GT,EQ,SO}
//
// Parameters
//   XER_RST   XER value loaded on reset
//   CR_RST    CR value loaded on reset
//
// Ports
//   clk       clock; all state updates on the rising edge
//   rst       synchronous active-high reset
//   D         ALU flags {CA,OV,LT0,GT0,EQ0,LTx,GTx,EQx}
//   upd_vld   ALU update valid; accepted when upd_vld & upd_rdy
//   ca_we     update writes XER[CA]
//   ov_we     update writes XER[OV]; XER[SO] becomes sticky-or'd with OV
//   cr0_we    update writes CR0 from D[2:4]
//   crx_we    update writes CR field crx_sel from D[5:7]
//   crx_sel   target CR field for crx_we
//   upd_rdy   hold buffer empty and not in reset
//   mt_vld    move-to op valid; always accepted
//   mt_op     00 MTXER, 01 MTCRF, 10 MCRXR, 11 no-op
//   mt_fxm    MTCRF field mask; bit i selects CR field i
//   mt_crf    MCRXR destination CR field
//   mt_data   source data for MTXER/MTCRF
//   XERrd     XER seen by the ALU
//   CRrd      CR seen by the ALU
//
// Build option
//   FLAG_BYPASS_EN : when defined, XERrd/CRrd show the value being written
//                    this cycle. A dependent ALU op in the same cycle then
//                    sees the new flags through a combinational path. When
//                    undefined, XERrd/CRrd come straight from the registers,
//                    and the pipeline interlock covers the one-cycle gap.
// ---------------------------------------------------------------------------
module flag_commit #(
  parameter logic [31:0] XER_RST = 32'h0000_0000,
  parameter logic [31:0] CR_RST  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:7]  D,
  input  logic        upd_vld,
  input  logic        ca_we,
  input  logic        ov_we,
  input  logic        cr0_we,
  input  logic        crx_we,
  input  logic [2:0]  crx_sel,
  output logic        upd_rdy,
  input  logic        mt_vld,
  input  logic [1:0]  mt_op,
  input  logic [0:7]  mt_fxm,
  input  logic [2:0]  mt_crf,
  input  logic [0:31] mt_data,
  output logic [0:31] XERrd,
  output logic [0:31] CRrd
);

  localparam logic [1:0] MT_XER  = 2'b00;
  localparam logic [1:0] MT_CRF  = 2'b01;
  localparam logic [1:0] MT_CRXR = 2'b10;

  typedef struct packed {
    logic [0:7] d;
    logic       ca_we;
    logic       ov_we;
    logic       cr0_we;
    logic       crx_we;
    logic [2:0] crx_sel;
  } upd_t;

  logic [0:31] xer_q, cr_q;
  logic [0:31] xer_nxt, cr_nxt;
  upd_t        hold_q, hold_nxt;
  logic        hold_full_q, hold_full_nxt;
  upd_t        port_upd;
  logic        upd_accept;
  logic        mt_active;

  // Apply one ALU update to the given flag state. SO is sticky: it can only
  // be set here, never cleared. Both CR writes carry the new SO. The crx
  // write comes last, so it wins when both writes target field 0.
  function automatic logic [0:63] apply_upd(input logic [0:31] xer,
                                            input logic [0:31] cr,
                                            input upd_t        u);
    logic        so_new;
    logic [0:31] x;
    logic [0:31] c;
    x      = xer;
    c      = cr;
    so_new = xer[0] | (u.ov_we & u.d[1]);
    x[0]   = so_new;
    if (u.ov_we) x[1] = u.d[1];
    if (u.ca_we) x[2] = u.d[0];
    if (u.cr0_we) c[0:3] = {u.d[2:4], so_new};
    if (u.crx_we) c[{u.crx_sel, 2'b00} +: 4] = {u.d[5:7], so_new};
    return {x, c};
  endfunction

  assign port_upd   = '{d: D, ca_we: ca_we, ov_we: ov_we, cr0_we: cr0_we,
                        crx_we: crx_we, crx_sel: crx_sel};
  assign upd_rdy    = ~hold_full_q & ~rst;
  assign upd_accept = upd_vld & upd_rdy;
  assign mt_active  = mt_vld & (mt_op != 2'b11);

  // Next-state selection. Within a cycle, a move-to op takes precedence.
  // If it collides with an accepted port update, that update is parked in
  // the hold buffer. A parked update drains on the first cycle without a
  // move-to op. A fresh port update can only apply when the buffer is empty.
  always_comb begin
    xer_nxt       = xer_q;
    cr_nxt        = cr_q;
    hold_nxt      = hold_q;
    hold_full_nxt = hold_full_q;
    if (mt_active) begin
      case (mt_op)
        MT_XER: xer_nxt = mt_data;
        MT_CRF: begin
          for (int i = 0; i < 8; i++) begin
            if (mt_fxm[i]) cr_nxt[4*i +: 4] = mt_data[4*i +: 4];
          end
        end
        MT_CRXR: begin
          cr_nxt[{mt_crf, 2'b00} +: 4] = xer_q[0:3];
          xer_nxt[0:3]                 = 4'b0000;
        end
        default: ;
      endcase
      if (upd_accept) begin
        hold_nxt      = port_upd;
        hold_full_nxt = 1'b1;
      end
    end else if (hold_full_q) begin
      {xer_nxt, cr_nxt} = apply_upd(xer_q, cr_q, hold_q);
      hold_full_nxt     = 1'b0;
    end else if (upd_accept) begin
      {xer_nxt, cr_nxt} = apply_upd(xer_q, cr_q, port_upd);
    end
  end

  // State registers. A reset that arrives while an update is parked
  // throws that update away along with the rest of the flag state.
  always_ff @(posedge clk) begin
    if (rst) begin
      xer_q       <= XER_RST;
      cr_q        <= CR_RST;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      xer_q       <= xer_nxt;
      cr_q        <= cr_nxt;
      hold_q      <= hold_nxt;
      hold_full_q <= hold_full_nxt;
    end
  end

`ifdef FLAG_BYPASS_EN
  assign XERrd = xer_nxt;
  assign CRrd  = cr_nxt;
`else
  assign XERrd = xer_q;
  assign CRrd  = cr_q;
`endif

endmodule

// File: tb/tb_flag_commit.sv
// ---------------------------------------------------------------------------
// tb_flag_commit
//
// Self-checking bench for flag_commit. Every applied stimulus is fed to a
// bit-level reference model. The model's predicted XER/CR/upd_rdy goes onto
// a scoreboard queue, and each entry is popped and compared just after the
// clock edge. Directed scenarios add fixed-value checks on top of that.
// ---------------------------------------------------------------------------
module tb_flag_commit;

  localparam logic [0:31] XER_RST_TB = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:7]  D;
  logic        upd_vld, ca_we, ov_we, cr0_we, crx_we;
  logic [2:0]  crx_sel;
  logic        upd_rdy;
  logic        mt_vld;
  logic [1:0]  mt_op;
  logic [0:7]  mt_fxm;
  logic [2:0]  mt_crf;
  logic [0:31] mt_data;
  logic [0:31] XERrd, CRrd;

  int vec_count  = 0;
  int miscompares = 0;

  typedef struct {
    logic        rst;
    logic        upd_vld;
    logic [0:7]  d;
    logic        ca_we, ov_we, cr0_we, crx_we;
    logic [2:0]  crx_sel;
    logic        mt_vld;
    logic [1:0]  mt_op;
    logic [0:7]  fxm;
    logic [2:0]  crf;
    logic [0:31] data;
  } stim_t;

  typedef struct {
    logic [0:31] x;
    logic [0:31] c;
    logic        rdy;
  } exp_t;

  exp_t        sb[$];
  stim_t       cur;
  logic [0:31] m_xer, m_cr;
  logic        m_full;
  stim_t       m_held;

  flag_commit #(.XER_RST(32'h2000_0000), .CR_RST(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .D(D), .upd_vld(upd_vld), .ca_we(ca_we),
    .ov_we(ov_we), .cr0_we(cr0_we), .crx_we(crx_we), .crx_sel(crx_sel),
    .upd_rdy(upd_rdy), .mt_vld(mt_vld), .mt_op(mt_op), .mt_fxm(mt_fxm),
    .mt_crf(mt_crf), .mt_data(mt_data), .XERrd(XERrd), .CRrd(CRrd)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 1'b0; s.upd_vld = 1'b0; s.d = '0;
    s.ca_we = 1'b0; s.ov_we = 1'b0; s.cr0_we = 1'b0; s.crx_we = 1'b0;
    s.crx_sel = '0; s.mt_vld = 1'b0; s.mt_op = 2'b11; s.fxm = '0;
    s.crf = '0; s.data = '0;
    return s;
  endfunction

  function automatic stim_t upd_stim(input logic [0:7] d, input logic ca,
                                     input logic ov, input logic cr0,
                                     input logic crx, input logic [2:0] sel);
    stim_t s = idle_stim();
    s.upd_vld = 1'b1; s.d = d; s.ca_we = ca; s.ov_we = ov;
    s.cr0_we = cr0; s.crx_we = crx; s.crx_sel = sel;
    return s;
  endfunction

  function automatic stim_t mt_stim(input stim_t base, input logic [1:0] op,
                                    input logic [0:7] fxm, input logic [2:0] crf,
                                    input logic [0:31] data);
    stim_t s = base;
    s.mt_vld = 1'b1; s.mt_op = op; s.fxm = fxm; s.crf = crf; s.data = data;
    return s;
  endfunction

  // Reference model: one ALU update, written bit by bit
  task automatic model_apply(input stim_t u);
    logic       so;
    logic [0:3] nib;
    int         base;
    so = m_xer[0] | (u.ov_we & u.d[1]);
    if (u.ca_we) m_xer[2] = u.d[0];
    if (u.ov_we) m_xer[1] = u.d[1];
    m_xer[0] = so;
    if (u.cr0_we) begin
      nib = {u.d[2], u.d[3], u.d[4], so};
      for (int b = 0; b < 4; b++) m_cr[b] = nib[b];
    end
    if (u.crx_we) begin
      nib  = {u.d[5], u.d[6], u.d[7], so};
      base = int'(u.crx_sel) * 4;
      for (int b = 0; b < 4; b++) m_cr[base + b] = nib[b];
    end
  endtask

  // Reference model: one clock edge with stimulus s
  task automatic model_step(input stim_t s);
    logic acc;
    int   base;
    if (s.rst) begin
      m_xer = XER_RST_TB; m_cr = '0; m_full = 1'b0;
    end else begin
      acc = s.upd_vld && !m_full;
      if (s.mt_vld && s.mt_op != 2'b11) begin
        if (s.mt_op == 2'b00) m_xer = s.data;
        else if (s.mt_op == 2'b01) begin
          for (int f = 0; f < 8; f++)
            if (s.fxm[f]) for (int b = 0; b < 4; b++) m_cr[4*f + b] = s.data[4*f + b];
        end else begin
          base = int'(s.crf) * 4;
          for (int b = 0; b < 4; b++) m_cr[base + b] = m_xer[b];
          for (int b = 0; b < 4; b++) m_xer[b] = 1'b0;
        end
        if (acc) begin m_held = s; m_full = 1'b1; end
      end else if (m_full) begin
        model_apply(m_held); m_full = 1'b0;
      end else if (acc) begin
        model_apply(s);
      end
    end
  endtask

  // Drive DUT inputs from a stimulus record
  task automatic applyStimulus(input stim_t s);
    cur = s;
    rst = s.rst; upd_vld = s.upd_vld; D = s.d; ca_we = s.ca_we;
    ov_we = s.ov_we; cr0_we = s.cr0_we; crx_we = s.crx_we;
    crx_sel = s.crx_sel; mt_vld = s.mt_vld; mt_op = s.mt_op;
    mt_fxm = s.fxm; mt_crf = s.crf; mt_data = s.data;
  endtask

  // Predict, push onto the scoreboard, then advance one clock edge
  task automatic tick();
    exp_t e;
    model_step(cur);
    e.x = m_xer; e.c = m_cr; e.rdy = !m_full && !cur.rst;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    stim_t s = idle_stim();
    s.rst = 1'b1;
    applyStimulus(s);
    #1;
    vec_count++;
    if (upd_rdy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdy_pre: upd_rdy=%b expected 0", upd_rdy);
    end
    tick();
    e = sb.pop_front();
    vec_count++;
    if (XERrd !== e.x || CRrd !== e.c || upd_rdy !== e.rdy) begin
      miscompares++;
      $display("[TB] FAIL reset_sb: got %h %h %b expected %h %h %b", XERrd, CRrd, upd_rdy, e.x, e.c, e.rdy);
    end
    vec_count++;
    if (XERrd !== 32'h2000_0000 || CRrd !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_value: XERrd=%h CRrd=%h expected 20000000 00000000", XERrd, CRrd);
    end
    applyStimulus(idle_stim());
    #1;
    vec_count++;
    if (upd_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_rdy_post: upd_rdy=%b expected 1", upd_rdy);
    end
  endtask

  task automatic test_overflow_sticky();
    exp_t  e;
    stim_t seq[3];
    seq[0] = mt_stim(idle_stim(), 2'b00, 8'h00, 3'd0, 32'h0);
    seq[1] = upd_stim(8'b01_100_000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    seq[2] = upd_stim(8'b00_000_000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(seq[i]);
      tick();
      e = sb.pop_front();
      vec_count++;
      if (XERrd !== e.x || CRrd !== e.c || upd_rdy !== e.rdy) begin
        miscompares++;
        $display("[TB] FAIL overflow_sb[%0d]: got %h %h %b expected %h %h %b", i, XERrd, CRrd, upd_rdy, e.x, e.c, e.rdy);
      end
      if (i == 1) begin
        vec_count++;
        if (XERrd[0:2] !== 3'b110 || CRrd[0:3] !== 4'b1001) begin
          miscompares++;
          $display("[TB] FAIL overflow_set: XER[0:2]=%b CR0=%b expected 110 1001", XERrd[0:2], CRrd[0:3]);
        end
      end
      if (i == 2) begin
        vec_count++;
        if (XERrd[0:1] !== 2'b10) begin
          miscompares++;
          $display("[TB] FAIL overflow_sticky: XER[0:1]=%b expected 10", XERrd[0:1]);
        end
      end
    end
  endtask

  task automatic test_compare();
    exp_t e;
    applyStimulus(upd_stim(8'b00_000_001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5));
    tick();
    e = sb.pop_front();
    vec_count++;
    if (XERrd !== e.x || CRrd !== e.c || upd_rdy !== e.rdy) begin
      miscompares++;
      $display("[TB] FAIL compare_sb: got %h %h %b expected %h %h %b", XERrd, CRrd, upd_rdy, e.x, e.c, e.rdy);
    end
    vec_count++;
    if (CRrd !== 32'h9000_0300) begin
      miscompares++;
      $display("[TB] FAIL compare_field5: CRrd=%h expected 90000300", CRrd);
    end
  endtask

  task automatic test_collision();
    exp_t  e;
    stim_t seq[4];
    seq[0] = mt_stim(idle_stim(), 2'b00, 8'h00, 3'd0, 32'h0);
    seq[1] = mt_stim(upd_stim(8'b00_010_000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0),
                     2'b01, 8'h80, 3'd0, 32'hF000_0000);
    seq[2] = idle_stim();
    seq[3] = idle_stim();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(seq[i]);
      tick();
      e = sb.pop_front();
      vec_count++;
      if (XERrd !== e.x || CRrd !== e.c || upd_rdy !== e.rdy) begin
        miscompares++;
        $display("[TB] FAIL collision_sb[%0d]: got %h %h %b expected %h %h %b", i, XERrd, CRrd, upd_rdy, e.x, e.c, e.rdy);
      end
      if (i == 1 || i == 2) begin
        vec_count++;
        if (CRrd[0:3] !== ((i == 1) ? 4'b1111 : 4'b0100) || upd_rdy !== (i == 2)) begin
          miscompares++;
          $display("[TB] FAIL collision_step%0d: CR0=%b upd_rdy=%b", i, CRrd[0:3], upd_rdy);
        end
      end
    end
  endtask

  task automatic test_hold_under_mt();
    exp_t  e;
    stim_t seq[5];
    stim_t nxt = upd_stim(8'b00_001_000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    seq[0] = mt_stim(upd_stim(8'b10_000_000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0),
                     2'b00, 8'h00, 3'd0, 32'h0);
    seq[1] = mt_stim(nxt, 2'b01, 8'h01, 3'd0, 32'h0000_000F);
    seq[2] = nxt;
    seq[3] = nxt;
    seq[4] = idle_stim();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(seq[i]);
      tick();
      e = sb.pop_front();
      vec_count++;
      if (XERrd !== e.x || CRrd !== e.c || upd_rdy !== e.rdy) begin
        miscompares++;
        $display("[TB] FAIL hold_sb[%0d]: got %h %h %b expected %h %h %b", i, XERrd, CRrd, upd_rdy, e.x, e.c, e.rdy);
      end
      if (i == 1) begin
        vec_count++;
        if (upd_rdy !== 1'b0 || CRrd[28:31] !== 4'hF || XERrd[2] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL hold_kept: upd_rdy=%b CR7=%b CA=%b expected 0 1111 0", upd_rdy, CRrd[28:31], XERrd[2]);
        end
      end
      if (i == 3) begin
        vec_count++;
        if (XERrd[2] !== 1'b1 || CRrd[0:3] !== 4'b0010) begin
          miscompares++;
          $display("[TB] FAIL hold_drain: CA=%b CR0=%b expected 1 0010", XERrd[2], CRrd[0:3]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t  e;
    stim_t seq[3];
    seq[0] = mt_stim(upd_stim(8'b00_000_111, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7),
                     2'b00, 8'h00, 3'd0, 32'h0);
    seq[1] = idle_stim();
    seq[1].rst = 1'b1;
    seq[2] = idle_stim();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(seq[i]);
      tick();
      e = sb.pop_front();
      vec_count++;
      if (XERrd !== e.x || CRrd !== e.c || upd_rdy !== e.rdy) begin
        miscompares++;
        $display("[TB] FAIL rstHold_sb[%0d]: got %h %h %b expected %h %h %b", i, XERrd, CRrd, upd_rdy, e.x, e.c, e.rdy);
      end
    end
    vec_count++;
    if (XERrd !== 32'h2000_0000 || CRrd !== 32'h0 || upd_rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstHold_dropped: XERrd=%h CRrd=%h upd_rdy=%b", XERrd, CRrd, upd_rdy);
    end
  endtask

  task automatic test_field0_conflict();
    exp_t e;
    applyStimulus(upd_stim(8'b00_100_010, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0));
    tick();
    e = sb.pop_front();
    vec_count++;
    if (XERrd !== e.x || CRrd !== e.c || upd_rdy !== e.rdy) begin
      miscompares++;
      $display("[TB] FAIL field0_sb: got %h %h %b expected %h %h %b", XERrd, CRrd, upd_rdy, e.x, e.c, e.rdy);
    end
    vec_count++;
    if (CRrd[0:3] !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL field0_crx_wins: CR0=%b expected 0100", CRrd[0:3]);
    end
  endtask

  task automatic test_mcrxr();
    exp_t  e;
    stim_t seq[2];
    seq[0] = mt_stim(idle_stim(), 2'b00, 8'h00, 3'd0, 32'hE000_0000);
    seq[1] = mt_stim(idle_stim(), 2'b10, 8'h00, 3'd3, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(seq[i]);
      tick();
      e = sb.pop_front();
      vec_count++;
      if (XERrd !== e.x || CRrd !== e.c || upd_rdy !== e.rdy) begin
        miscompares++;
        $display("[TB] FAIL mcrxr_sb[%0d]: got %h %h %b expected %h %h %b", i, XERrd, CRrd, upd_rdy, e.x, e.c, e.rdy);
      end
    end
    vec_count++;
    if (CRrd[12:15] !== 4'b1110 || XERrd[0:3] !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL mcrxr_move: CR3=%b XER[0:3]=%b expected 1110 0000", CRrd[12:15], XERrd[0:3]);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic pre_exp;
`ifdef FLAG_BYPASS_EN
    pre_exp = 1'b1;
`else
    pre_exp = 1'b0;
`endif
    applyStimulus(upd_stim(8'b10_000_000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
    #1;
    vec_count++;
    if (XERrd[2] !== pre_exp) begin
      miscompares++;
      $display("[TB] FAIL bypass_same_cycle: CA=%b expected %b", XERrd[2], pre_exp);
    end
    tick();
    e = sb.pop_front();
    applyStimulus(idle_stim());
    #1;
    vec_count++;
    if (XERrd !== e.x || CRrd !== e.c || XERrd[2] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bypass_next_cycle: got %h %h expected %h %h", XERrd, CRrd, e.x, e.c);
    end
  endtask

  task automatic test_back_to_back();
    exp_t  e;
    stim_t s;
    stim_t prev = idle_stim();
    logic  blocked;
    for (int i = 0; i < 300; i++) begin
      blocked = prev.upd_vld && (m_full || prev.rst);
      s = idle_stim();
      if (blocked) begin
        s.upd_vld = 1'b1; s.d = prev.d; s.ca_we = prev.ca_we; s.ov_we = prev.ov_we;
        s.cr0_we = prev.cr0_we; s.crx_we = prev.crx_we; s.crx_sel = prev.crx_sel;
      end else if ($urandom_range(0, 3) != 0) begin
        s = upd_stim(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 3'($urandom));
      end
      if ($urandom_range(0, 2) == 0)
        s = mt_stim(s, 2'($urandom), 8'($urandom), 3'($urandom), $urandom);
      s.rst = ($urandom_range(0, 63) == 0);
      prev = s;
      applyStimulus(s);
      tick();
      e = sb.pop_front();
      vec_count++;
      if (XERrd !== e.x || CRrd !== e.c || upd_rdy !== e.rdy) begin
        miscompares++;
        $display("[TB] FAIL random_sb[%0d]: got %h %h %b expected %h %h %b", i, XERrd, CRrd, upd_rdy, e.x, e.c, e.rdy);
      end
    end
  endtask

  // Main sequence
  initial begin
    applyStimulus(idle_stim());
    @(posedge clk);
    #1;
    test_reset();
    test_overflow_sticky();
    test_compare();
    test_collision();
    test_hold_under_mt();
    test_reset_mid_hold();
    test_field0_conflict();
    test_mcrxr();
    test_bypass();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
